gnn_mlp_engine: RTL and testbench

- Parametrised, time-multiplexed successor to the fixed 4-node, 4-feature, two-layer GNN datapath.
- Computes, per node, hidden = X·W1 and then Y = hidden·W2 using one shared signed MAC, with valid/ready handshakes on input and output.
- Sits between the node-feature/weight load logic and the result collector.
- Node, feature, hidden, output and data widths are all parameters.

---
 rtl/gnn_mlp_engine.sv | 191 +++++++++++++++++++
 tb/tb_gnn_mlp_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_mlp_engine.sv
// gnn_mlp_engine: time-multiplexed two-layer GNN MLP (hidden = X*W1, Y = hidden*W2) on one shared signed MAC.
// Optional GNN_HIDDEN_RELU_EN clamps hidden values at zero before layer 2.  Rev 1.0
`default_nettype none

module gnn_mlp_engine #(
  parameter int NODES = 4,
  parameter int FEAT  = 4,
  parameter int HID   = 4,
  parameter int OUTS  = 2,
  parameter int DW    = 5,
  parameter int OW    = 21
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NODES*FEAT*DW-1:0]    x,
  input  logic [FEAT*HID*DW-1:0]      w1,
  input  logic [HID*OUTS*DW-1:0]      w2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NODES*OUTS*OW-1:0]    y,
  output logic                        busy
);

  localparam int HW  = 2*DW + $clog2(FEAT);
  localparam int NW  = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int FW  = (FEAT  > 1) ? $clog2(FEAT)  : 1;
  localparam int HCW = (HID   > 1) ? $clog2(HID)   : 1;
  localparam int OCW = (OUTS  > 1) ? $clog2(OUTS)  : 1;

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;
  state_t state, state_nxt;

  logic [NW-1:0]  n_cnt;
  logic [HCW-1:0] h_cnt;
  logic [FW-1:0]  f_cnt;
  logic [OCW-1:0] o_cnt;

  logic signed [DW-1:0] x_r  [NODES][FEAT];
  logic signed [DW-1:0] w1_r [FEAT][HID];
  logic signed [DW-1:0] w2_r [HID][OUTS];
  logic signed [HW-1:0] hid  [NODES][HID];
  logic signed [OW-1:0] res  [NODES][OUTS];

  logic signed [OW-1:0] acc, op_a, op_b, prod, sum;
  logic signed [HW-1:0] hid_val;
  logic inner_last, mid_last, node_last, layer_done, accept;

  // Operand select: both layers share the same multiplier, widened to OW so the product never overflows.
  always_comb begin
    op_a       = '0;
    op_b       = '0;
    inner_last = 1'b0;
    mid_last   = 1'b0;
    node_last  = (n_cnt == NW'(NODES-1));
    case (state)
      L1: begin
        op_a       = {{(OW-DW){x_r[n_cnt][f_cnt][DW-1]}}, x_r[n_cnt][f_cnt]};
        op_b       = {{(OW-DW){w1_r[f_cnt][h_cnt][DW-1]}}, w1_r[f_cnt][h_cnt]};
        inner_last = (f_cnt == FW'(FEAT-1));
        mid_last   = (h_cnt == HCW'(HID-1));
      end
      L2: begin
        op_a       = {{(OW-HW){hid[n_cnt][h_cnt][HW-1]}}, hid[n_cnt][h_cnt]};
        op_b       = {{(OW-DW){w2_r[h_cnt][o_cnt][DW-1]}}, w2_r[h_cnt][o_cnt]};
        inner_last = (h_cnt == HCW'(HID-1));
        mid_last   = (o_cnt == OCW'(OUTS-1));
      end
      default: ;
    endcase
    layer_done = inner_last && mid_last && node_last;
    prod       = op_a * op_b;
    sum        = acc + prod;
`ifdef GNN_HIDDEN_RELU_EN
    hid_val    = sum[OW-1] ? '0 : sum[HW-1:0];
`else
    hid_val    = sum[HW-1:0];
`endif
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_nxt = L1;
      end
      L1: begin
        busy = 1'b1;
        if (layer_done) state_nxt = L2;
      end
      L2: begin
        busy = 1'b1;
        if (layer_done) state_nxt = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_cnt     <= '0;
      h_cnt     <= '0;
      f_cnt     <= '0;
      o_cnt     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      for (int n = 0; n < NODES; n++) begin
        for (int h = 0; h < HID; h++)  hid[n][h] <= '0;
        for (int o = 0; o < OUTS; o++) res[n][o] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int n = 0; n < NODES; n++)
              for (int f = 0; f < FEAT; f++)
                x_r[n][f] <= x[(n*FEAT+f)*DW +: DW];
            for (int f = 0; f < FEAT; f++)
              for (int h = 0; h < HID; h++)
                w1_r[f][h] <= w1[(f*HID+h)*DW +: DW];
            for (int h = 0; h < HID; h++)
              for (int o = 0; o < OUTS; o++)
                w2_r[h][o] <= w2[(h*OUTS+o)*DW +: DW];
          end
        end
        L1: begin
          if (inner_last) begin
            hid[n_cnt][h_cnt] <= hid_val;
            acc   <= '0;
            f_cnt <= '0;
            if (mid_last) begin
              h_cnt <= '0;
              n_cnt <= node_last ? '0 : n_cnt + NW'(1);
            end else begin
              h_cnt <= h_cnt + HCW'(1);
            end
          end else begin
            acc   <= sum;
            f_cnt <= f_cnt + FW'(1);
          end
        end
        L2: begin
          if (inner_last) begin
            res[n_cnt][o_cnt] <= sum;
            acc   <= '0;
            h_cnt <= '0;
            if (mid_last) begin
              o_cnt <= '0;
              n_cnt <= node_last ? '0 : n_cnt + NW'(1);
            end else begin
              o_cnt <= o_cnt + OCW'(1);
            end
            // The last result is still in flight on this edge, so it is taken from sum directly.
            if (layer_done) begin
              for (int n = 0; n < NODES; n++)
                for (int o = 0; o < OUTS; o++)
                  y[(n*OUTS+o)*OW +: OW] <= res[n][o];
              y[((NODES-1)*OUTS+OUTS-1)*OW +: OW] <= sum;
              out_valid <= 1'b1;
            end
          end else begin
            acc   <= sum;
            h_cnt <= h_cnt + HCW'(1);
          end
        end
        DONE: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gnn_mlp_engine.sv
// tb_gnn_mlp_engine: randomized self-checking bench for gnn_mlp_engine against an integer reference model.
`timescale 1ns/1ps
module tb_gnn_mlp_engine;
  localparam int NODES = 4, FEAT = 4, HID = 4, OUTS = 2, DW = 5, OW = 21;
  localparam int LAT = NODES*HID*FEAT + NODES*OUTS*HID;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [NODES*FEAT*DW-1:0] x  = '0;
  logic [FEAT*HID*DW-1:0]   w1 = '0;
  logic [HID*OUTS*DW-1:0]   w2 = '0;
  logic [NODES*OUTS*OW-1:0] y;

  gnn_mlp_engine #(.NODES(NODES), .FEAT(FEAT), .HID(HID), .OUTS(OUTS), .DW(DW), .OW(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .w1(w1), .w2(w2),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy));

  logic p_in_valid = 1'b0, p_out_ready = 1'b0;
  logic p_in_ready, p_out_valid, p_busy;
  logic [3*2*4-1:0]  p_x  = '0;
  logic [2*3*4-1:0]  p_w1 = '0;
  logic [3*1*4-1:0]  p_w2 = '0;
  logic [3*1*16-1:0] p_y;

  gnn_mlp_engine #(.NODES(3), .FEAT(2), .HID(3), .OUTS(1), .DW(4), .OW(16)) dut_p (
    .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready), .x(p_x), .w1(p_w1), .w2(p_w2),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .y(p_y), .busy(p_busy));

  int checks = 0, errors = 0;
  int mx [NODES][FEAT];
  int mw1[FEAT][HID];
  int mw2[HID][OUTS];
  int ey [NODES][OUTS];

  task automatic pack_and_model();
    int hv [NODES][HID];
    int s;
    for (int n = 0; n < NODES; n++)
      for (int f = 0; f < FEAT; f++) x[(n*FEAT+f)*DW +: DW] = mx[n][f][DW-1:0];
    for (int f = 0; f < FEAT; f++)
      for (int h = 0; h < HID; h++) w1[(f*HID+h)*DW +: DW] = mw1[f][h][DW-1:0];
    for (int h = 0; h < HID; h++)
      for (int o = 0; o < OUTS; o++) w2[(h*OUTS+o)*DW +: DW] = mw2[h][o][DW-1:0];
    for (int n = 0; n < NODES; n++)
      for (int h = 0; h < HID; h++) begin
        s = 0;
        for (int f = 0; f < FEAT; f++) s += mx[n][f] * mw1[f][h];
`ifdef GNN_HIDDEN_RELU_EN
        if (s < 0) s = 0;
`endif
        hv[n][h] = s;
      end
    for (int n = 0; n < NODES; n++)
      for (int o = 0; o < OUTS; o++) begin
        s = 0;
        for (int h = 0; h < HID; h++) s += hv[n][h] * mw2[h][o];
        ey[n][o] = s;
      end
  endtask

  task automatic fill(input int xv, input int w1v, input int w2v);
    for (int n = 0; n < NODES; n++) for (int f = 0; f < FEAT; f++) mx[n][f] = xv;
    for (int f = 0; f < FEAT; f++) for (int h = 0; h < HID; h++) mw1[f][h] = w1v;
    for (int h = 0; h < HID; h++) for (int o = 0; o < OUTS; o++) mw2[h][o] = w2v;
  endtask

  task automatic fill_random();
    for (int n = 0; n < NODES; n++) for (int f = 0; f < FEAT; f++) mx[n][f] = int'($urandom_range(0, 31)) - 16;
    for (int f = 0; f < FEAT; f++) for (int h = 0; h < HID; h++) mw1[f][h] = int'($urandom_range(0, 31)) - 16;
    for (int h = 0; h < HID; h++) for (int o = 0; o < OUTS; o++) mw2[h][o] = int'($urandom_range(0, 31)) - 16;
  endtask

  // Drives one transaction; lat counts edges from acceptance to out_valid, -1 on timeout.
  task automatic run_op(output int lat);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 1000) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (y !== '0) begin errors++; $display("FAIL reset_y got %h want 0", y); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_const(input string name, input int v1, input int v2, input int v3, input int expect_y);
    int lat, got;
    fill(v1, v2, v3);
    pack_and_model();
    run_op(lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, LAT); end
    for (int n = 0; n < NODES; n++)
      for (int o = 0; o < OUTS; o++) begin
        got = $signed(y[(n*OUTS+o)*OW +: OW]);
        checks++; if (got != expect_y) begin errors++; $display("FAIL %s_y[%0d][%0d] got %0d want %0d", name, n, o, got, expect_y); end
      end
    release_out();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_handshake out_valid %b in_ready %b want 0/1", name, out_valid, in_ready); end
  endtask

  task automatic test_random(input int iters);
    int lat, got;
    for (int i = 0; i < iters; i++) begin
      fill_random();
      pack_and_model();
      run_op(lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL random%0d_latency got %0d want %0d", i, lat, LAT); end
      for (int n = 0; n < NODES; n++)
        for (int o = 0; o < OUTS; o++) begin
          got = $signed(y[(n*OUTS+o)*OW +: OW]);
          checks++; if (got != ey[n][o]) begin errors++; $display("FAIL random%0d_y[%0d][%0d] got %0d want %0d", i, n, o, got, ey[n][o]); end
        end
      release_out();
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    fill_random();
    pack_and_model();
    run_op(lat);
    release_out();
    @(negedge clk); in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy got %b want 1", busy); end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midop_rst_in_ready got %b want 0", in_ready); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (y !== '0) begin errors++; $display("FAIL midop_y got %h want 0", y); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midop_flags out_valid %b busy %b want 0/0", out_valid, busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midop_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic [NODES*OUTS*OW-1:0] held;
    int lat, got, guard;
    fill_random();
    pack_and_model();
    @(negedge clk); in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 1000) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != LAT) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, LAT); end
    for (int n = 0; n < NODES; n++)
      for (int o = 0; o < OUTS; o++) begin
        got = $signed(y[(n*OUTS+o)*OW +: OW]);
        checks++; if (got != ey[n][o]) begin errors++; $display("FAIL bp_y[%0d][%0d] got %0d want %0d", n, o, got, ey[n][o]); end
      end
    held = y;
    fill_random();
    pack_and_model();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++; if (y !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d y_changed %b out_valid %b in_ready %b busy %b want 0/1/0/0",
                           c, y !== held, out_valid, in_ready, busy); end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release out_valid %b in_ready %b want 0/1", out_valid, in_ready); end
    checks++; if (y !== held) begin errors++; $display("FAIL bp_y_hold_after_release got %h want %h", y, held); end
    @(posedge clk); #1; in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_reaccept busy got %b want 1", busy); end
    guard = 0;
    while (!out_valid && guard < 1000) begin @(posedge clk); #1; guard++; end
    for (int n = 0; n < NODES; n++)
      for (int o = 0; o < OUTS; o++) begin
        got = $signed(y[(n*OUTS+o)*OW +: OW]);
        checks++; if (got != ey[n][o]) begin errors++; $display("FAIL bp2_y[%0d][%0d] got %0d want %0d", n, o, got, ey[n][o]); end
      end
    release_out();
  endtask

  task automatic test_parametric();
    int lat, got, want;
    for (int n = 0; n < 3; n++)
      for (int f = 0; f < 2; f++) p_x[(n*2+f)*4 +: 4] = 4'(n + f);
    for (int i = 0; i < 6; i++) p_w1[i*4 +: 4] = 4'd1;
    for (int i = 0; i < 3; i++) p_w2[i*4 +: 4] = 4'd2;
    @(negedge clk);
    checks++; if (p_in_ready !== 1'b1) begin errors++; $display("FAIL param_in_ready got %b want 1", p_in_ready); end
    p_in_valid = 1'b1;
    @(posedge clk); #1; p_in_valid = 1'b0;
    lat = 0;
    while (!p_out_valid && lat < 500) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 27) begin errors++; $display("FAIL param_latency got %0d want 27", lat); end
    for (int n = 0; n < 3; n++) begin
      got  = $signed(p_y[n*16 +: 16]);
      want = 6 * (2*n + 1);
      checks++; if (got != want) begin errors++; $display("FAIL param_y[%0d] got %0d want %0d", n, got, want); end
    end
    @(negedge clk); p_out_ready = 1'b1;
    @(posedge clk); #1; p_out_ready = 1'b0;
    checks++; if (p_out_valid !== 1'b0) begin errors++; $display("FAIL param_release out_valid got %b want 0", p_out_valid); end
  endtask

  initial begin
    int relu_y;
`ifdef GNN_HIDDEN_RELU_EN
    relu_y = 0;
`else
    relu_y = -16;
`endif
    test_reset();
    test_const("max", 15, 15, 15, 54000);
    test_const("min", -16, -16, -16, -65536);
    test_const("relu", 1, -1, 1, relu_y);
    test_random(6);
    test_backpressure();
    test_reset_mid_op();
    test_parametric();
    test_random(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
